// File: rtl/ysyx_22050019_icache_assoc.sv
// N-way set-associative read-only icache between IFU and AXI read master, with bypass window,
// iterative fence.i flush, error propagation and hit/miss counters. Storage lives in flop arrays.
module ysyx_22050019_icache_assoc #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    WAYS          = 4,
  parameter int                    SETS          = 64,
  parameter int                    LINE_BEATS    = 2,
  parameter logic [ADDR_WIDTH-1:0] UNCACHED_BASE = 32'hA0000000,
  parameter logic [ADDR_WIDTH-1:0] UNCACHED_MASK = 32'hF0000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  cache_ar_valid_o,
  input  logic                  cache_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] cache_ar_addr_o,
  output logic [7:0]            cache_ar_len_o,
  input  logic                  cache_r_valid_i,
  output logic                  cache_r_ready_o,
  input  logic [DATA_WIDTH-1:0] cache_r_data_i,
  input  logic [1:0]            cache_r_resp_i,
  input  logic                  cache_r_last_i,
  input  logic                  fence_i_i,
  output logic                  fence_busy_o,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int BW     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_BEATS * DATA_WIDTH / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WW     = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, RESP, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WW-1:0]         victim_q, victim_d;
  logic [WW-1:0]         rr_q, rr_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  bypass_q, bypass_d;
  logic [IDX_W-1:0]      flush_idx_q, flush_idx_d;
  logic                  fence_pend_q, fence_pend_d;
  logic                  ar_ready_q, ar_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  cache_ar_valid_q, cache_ar_valid_d;
  logic [ADDR_WIDTH-1:0] cache_ar_addr_q, cache_ar_addr_d;
  logic [7:0]            cache_ar_len_q, cache_ar_len_d;
  logic                  cache_r_ready_q, cache_r_ready_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS][LINE_BEATS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [SETS-1:0]       valid_q [WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [BW-1:0]    beat_sel;
  logic             uncached;
  logic             hit, inv_found;
  logic [WW-1:0]    hit_way, inv_way;
  logic             ar_hs, bus_ar_hs, beat_hs, burst_end, resp_hs, flush_done;
  logic             beat_err, fill_we, tag_we;

  assign idx      = addr_q[OFF_W +: IDX_W];
  assign tag      = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign beat_sel = (LINE_BEATS > 1) ? addr_q[BYTE_W +: BW] : '0;
  assign uncached = (addr_q & UNCACHED_MASK) == UNCACHED_BASE;

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  assign ar_hs      = (state_q == IDLE) && ar_ready_q && ar_valid_i && !fence_pend_q;
  assign bus_ar_hs  = cache_ar_valid_q && cache_ar_ready_i;
  assign beat_hs    = (state_q == MISS_R) && cache_r_ready_q && cache_r_valid_i;
  assign burst_end  = beat_hs && (cache_r_last_i || bypass_q || (beat_q == BW'(LINE_BEATS - 1)));
  assign resp_hs    = r_valid_q && r_ready_i;
  assign flush_done = (state_q == FLUSH) && (flush_idx_q == IDX_W'(SETS - 1));
  assign beat_err   = beat_hs && (cache_r_resp_i != 2'b00);
  assign fill_we    = beat_hs && !bypass_q;
  assign tag_we     = burst_end && !bypass_q && !(err_q || beat_err);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fence_pend_q) state_d = FLUSH;
               else if (ar_hs)   state_d = LOOKUP;
      LOOKUP:  state_d = (uncached || !hit) ? MISS_AR : RESP;
      MISS_AR: if (bus_ar_hs)  state_d = MISS_R;
      MISS_R:  if (burst_end)  state_d = RESP;
      RESP:    if (resp_hs)    state_d = IDLE;
      FLUSH:   if (flush_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d          = ar_hs ? ar_addr_i : addr_q;
    victim_d        = victim_q;
    rr_d            = rr_q + WW'(1);
    beat_d          = beat_q;
    err_d           = err_q;
    bypass_d        = bypass_q;
    flush_idx_d     = flush_idx_q;
    r_data_d        = r_data_q;
    r_resp_d        = r_resp_q;
    cache_ar_addr_d = cache_ar_addr_q;
    cache_ar_len_d  = cache_ar_len_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;

    if (ar_hs) err_d = 1'b0;
    if (state_q == LOOKUP) begin
      bypass_d        = uncached;
      victim_d        = inv_found ? inv_way : rr_q;
      cache_ar_addr_d = uncached ? addr_q : {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      cache_ar_len_d  = uncached ? 8'd0 : 8'(LINE_BEATS - 1);
      if (!uncached && hit) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
        r_data_d  = data_q[hit_way][idx][beat_sel];
        r_resp_d  = 2'b00;
      end else if (!uncached) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
    if (bus_ar_hs) beat_d = '0;
    if (beat_hs) begin
      beat_d = beat_q + BW'(1);
      if (beat_err) err_d = 1'b1;
      if (bypass_q || (beat_q == beat_sel)) r_data_d = cache_r_data_i;
    end
    if (burst_end) r_resp_d = (err_q || beat_err) ? 2'b10 : 2'b00;
    if (resp_hs)   r_resp_d = 2'b00;
    if (state_q == FLUSH) flush_idx_d = flush_idx_q + IDX_W'(1);

    // Pulses landing while a flush is pending or running fold into that flush.
    fence_pend_d     = flush_done ? 1'b0 : (fence_pend_q || fence_i_i);
    ar_ready_d       = (state_d == IDLE) && !fence_pend_d;
    r_valid_d        = (state_d == RESP);
    cache_ar_valid_d = (state_d == MISS_AR);
    cache_r_ready_d  = (state_d == MISS_R);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      victim_q         <= '0;
      rr_q             <= '0;
      beat_q           <= '0;
      err_q            <= 1'b0;
      bypass_q         <= 1'b0;
      flush_idx_q      <= '0;
      fence_pend_q     <= 1'b0;
      ar_ready_q       <= 1'b0;
      r_valid_q        <= 1'b0;
      r_data_q         <= '0;
      r_resp_q         <= 2'b00;
      cache_ar_valid_q <= 1'b0;
      cache_ar_addr_q  <= '0;
      cache_ar_len_q   <= '0;
      cache_r_ready_q  <= 1'b0;
      hit_cnt_q        <= '0;
      miss_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      victim_q         <= victim_d;
      rr_q             <= rr_d;
      beat_q           <= beat_d;
      err_q            <= err_d;
      bypass_q         <= bypass_d;
      flush_idx_q      <= flush_idx_d;
      fence_pend_q     <= fence_pend_d;
      ar_ready_q       <= ar_ready_d;
      r_valid_q        <= r_valid_d;
      r_data_q         <= r_data_d;
      r_resp_q         <= r_resp_d;
      cache_ar_valid_q <= cache_ar_valid_d;
      cache_ar_addr_q  <= cache_ar_addr_d;
      cache_ar_len_q   <= cache_ar_len_d;
      cache_r_ready_q  <= cache_r_ready_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_q[victim_q][idx][beat_q] <= cache_r_data_i;
    if (tag_we)  tag_q[victim_q][idx] <= tag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      if (state_q == FLUSH) begin
        for (int w = 0; w < WAYS; w++) valid_q[w][flush_idx_q] <= 1'b0;
      end
      if (tag_we) valid_q[victim_q][idx] <= 1'b1;
    end
  end

  assign ar_ready_o       = ar_ready_q;
  assign r_valid_o        = r_valid_q;
  assign r_data_o         = r_data_q;
  assign r_resp_o         = r_resp_q;
  assign cache_ar_valid_o = cache_ar_valid_q;
  assign cache_ar_addr_o  = cache_ar_addr_q;
  assign cache_ar_len_o   = cache_ar_len_q;
  assign cache_r_ready_o  = cache_r_ready_q;
  assign fence_busy_o     = fence_pend_q;
  assign hit_cnt_o        = hit_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;

endmodule
